// File: rtl/mult_booth_pkg.sv
// Shared types for the radix-2 Booth multiplier datapath: the control word and
// the recode-pair encodings the external controller decodes from Q_LSB[1:0].
package mult_booth_pkg;

  typedef struct packed {
    logic load_A;
    logic load_B;
    logic load_add;
    logic shift_HQ_LQ_Q_1;
    logic add_sub;
  } mult_control_t;

  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/mult_booth_add_sub.sv
// Combinational W-bit wrapping adder/subtractor (module_add_sub): y = a + b, or a - b when sub_i.
module module_add_sub #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = sub_i ? (a_i - b_i) : (a_i + b_i);
  end

endmodule

// File: rtl/mult_booth.sv
// Radix-2 Booth multiplier datapath; sequencing lives in an external controller.
// Define MULT_BOOTH_ASSERT_EN to compile in the SVA checks.
module mult_booth
  import mult_booth_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  mult_control_t mult_control,
  output logic [2:0]    Q_LSB,
  output logic [2*N-1:0] Y
);

  logic [N-1:0] m_q, m_d;
  logic [N:0]   hq_q, hq_d;
  logic [N-1:0] lq_q, lq_d;
  logic         q1_q, q1_d;
  logic [N:0]   hq_sum;
  logic [N:0]   hq_acc;

  // HQ carries one extra sign bit so subtracting the most-negative M cannot overflow.
  module_add_sub #(
    .W (N + 1)
  ) u_add_sub (
    .a_i   (hq_q),
    .b_i   ({m_q[N-1], m_q}),
    .sub_i (mult_control.add_sub),
    .y_o   (hq_sum)
  );

  always_comb begin
    m_d    = mult_control.load_A ? A : m_q;
    hq_acc = mult_control.load_add ? hq_sum : hq_q;
    hq_d   = hq_q;
    lq_d   = lq_q;
    q1_d   = q1_q;
    if (mult_control.load_B) begin
      hq_d = '0;
      lq_d = B;
      q1_d = 1'b0;
    end else if (mult_control.shift_HQ_LQ_Q_1) begin
      // Shift operates on the post-add accumulator: one full Booth step per clock.
      hq_d = {hq_acc[N], hq_acc[N:1]};
      lq_d = {hq_acc[0], lq_q[N-1:1]};
      q1_d = lq_q[0];
    end else begin
      hq_d = hq_acc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q  <= '0;
      hq_q <= '0;
      lq_q <= '0;
      q1_q <= 1'b0;
    end else begin
      m_q  <= m_d;
      hq_q <= hq_d;
      lq_q <= lq_d;
      q1_q <= q1_d;
    end
  end

  assign Y     = {hq_q[N-1:0], lq_q};
  assign Q_LSB = {lq_q[1:0], q1_q};

`ifdef MULT_BOOTH_ASSERT_EN
  a_no_add_with_load_b: assert property (@(posedge clk) disable iff (!rst)
    !(mult_control.load_B && mult_control.load_add));

  a_zero_in_reset: assert property (@(posedge clk)
    !rst |-> (Y == '0 && Q_LSB == 3'b000));

  a_ctrl_known: assert property (@(posedge clk) disable iff (!rst)
    !$isunknown(mult_control));
`else
`endif

endmodule

// File: tb/tb_mult_booth.sv
// Directed self-checking bench for mult_booth (N = 8) with a behavioural Booth controller.
module tb_mult_booth;
  import mult_booth_pkg::*;

  localparam int unsigned N = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  mult_control_t mult_control;
  logic [2:0]    Q_LSB;
  logic [2*N-1:0] Y;

  int checks = 0;
  int errors = 0;

  mult_booth #(
    .N (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .A            (A),
    .B            (B),
    .mult_control (mult_control),
    .Q_LSB        (Q_LSB),
    .Y            (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mult_control_t ctl(input logic la, input logic lb, input logic ld,
                                        input logic sh, input logic as);
    mult_control_t c;
    c.load_A          = la;
    c.load_B          = lb;
    c.load_add        = ld;
    c.shift_HQ_LQ_Q_1 = sh;
    c.add_sub         = as;
    return c;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one control word for one edge; outputs are sampled 1 time unit after the edge.
  task automatic apply(input mult_control_t c);
    mult_control = c;
    @(posedge clk);
    #1;
    mult_control = '0;
  endtask

  task automatic booth_steps(input int n, input bit comb);
    logic [1:0] rec;
    logic       do_add;
    logic       do_sub;
    for (int i = 0; i < n; i++) begin
      rec    = Q_LSB[2:1] == 2'b00 ? Q_LSB[1:0] : Q_LSB[1:0];
      do_add = (rec == BOOTH_ADD) || (rec == BOOTH_SUB);
      do_sub = (rec == BOOTH_SUB);
      if (comb) begin
        apply(ctl(1'b0, 1'b0, do_add, 1'b1, do_sub));
      end else begin
        if (do_add) apply(ctl(1'b0, 1'b0, 1'b1, 1'b0, do_sub));
        apply(ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      end
    end
  endtask

  task automatic mult(input logic [N-1:0] a, input logic [N-1:0] b, input bit comb);
    A = a;
    B = b;
    apply(ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    booth_steps(N, comb);
  endtask

  logic [N-1:0]          ra, rb;
  logic signed [2*N-1:0] prod;

  initial begin
    rst          = 1'b0;
    A            = '0;
    B            = '0;
    mult_control = '0;

    // Reset held with random inputs and control activity.
    for (int i = 0; i < 4; i++) begin
      A            = N'($urandom);
      B            = N'($urandom);
      mult_control = mult_control_t'($urandom_range(0, 31));
      @(posedge clk);
      #1;
      check("rst_Y", Y, 16'h0000);
      check("rst_QLSB", {13'b0, Q_LSB}, 16'h0000);
    end
    mult_control = '0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("post_rst_Y", Y, 16'h0000);
    check("post_rst_QLSB", {13'b0, Q_LSB}, 16'h0000);

    // Directed products.
    mult(8'h0B, 8'h0E, 1'b1);
    check("mul_0B_0E", Y, 16'h009A);
    mult(8'hFD, 8'h05, 1'b1);
    check("mul_FD_05", Y, 16'hFFF1);
    mult(8'h80, 8'h7F, 1'b1);
    check("mul_80_7F", Y, 16'hC080);
    mult(8'h80, 8'h80, 1'b1);
    check("mul_80_80", Y, 16'h4000);
    mult(8'h80, 8'h80, 1'b0);
    check("mul_80_80_sep", Y, 16'h4000);
    mult(8'hFF, 8'hFF, 1'b0);
    check("mul_FF_FF_sep", Y, 16'h0001);

    // Individual micro-operations and load_B priority.
    A = 8'h11;
    B = 8'h00;
    apply(ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    apply(ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    check("add_only", Y, 16'h1100);
    apply(ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    check("add_sub_ignored", Y, 16'h1100);
    B = 8'h3C;
    apply(ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    check("loadB_prio_Y", Y, 16'h003C);
    check("loadB_prio_QLSB", {13'b0, Q_LSB}, 16'h0000);
    B = 8'h00;
    apply(ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    apply(ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    check("sub_only", Y, 16'hEF00);
    apply(ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    check("ashr", Y, 16'hF780);
    apply(ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    check("hold", Y, 16'hF780);

    // Reset mid-multiplication, then a fresh multiplication.
    A = 8'h0B;
    B = 8'h0E;
    apply(ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    booth_steps(4, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_Y", Y, 16'h0000);
    check("mid_rst_QLSB", {13'b0, Q_LSB}, 16'h0000);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_hold", Y, 16'h0000);
    mult(8'h0B, 8'h0E, 1'b1);
    check("mul_after_rst", Y, 16'h009A);

    // Random pairs, combined and separate step forms.
    for (int i = 0; i < 500; i++) begin
      ra   = N'($urandom);
      rb   = N'($urandom);
      prod = $signed(ra) * $signed(rb);
      mult(ra, rb, 1'b1);
      check("rand_comb", Y, prod);
      mult(ra, rb, 1'b0);
      check("rand_sep", Y, prod);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
